// File: rtl/led_framebuffer.sv
// ---------------------------------------------------------------------------
// led_framebuffer
//
// Double-buffered pixel source for the LED panel driver. It holds two
// 64x64 RGB frame banks, split into a top-half array and a bottom-half
// array, so a single lookup yields both scan rows at once. A writer fills
// the back bank while the front bank is shown. The banks swap only when
// the driver's frame counter changes.
//
// Ports
//   clk          in   pixel clock, the panel driver's PLL clock
//   reset        in   asynchronous, active-high reset
//   wr_en        in   write strobe, one pixel per cycle
//   wr_x         in   write column
//   wr_y         in   write row; bit 5 selects the bottom-half array
//   wr_rgb       in   pixel value {r,g,b}, BPC bits each, r in the MSBs
//   swap_req     in   request a bank swap at the next frame boundary
//   swap_pending out  a swap has been requested and has not happened yet
//   swap_done    out  one-cycle pulse in the cycle after the swap happens
//   display_bank out  bank currently displayed; writes go to the other one
//   frame        in   driver frame counter
//   subframe     in   driver subframe counter; low BPC bits = PWM threshold
//   x            in   scan column
//   addr         in   scan row address (top row {0,addr}, bottom {1,addr})
//   rgb0         out  top-half {r,g,b} bits, 2 cycles after x/addr/subframe
//   rgb1         out  bottom-half {r,g,b} bits, 2 cycles after x/addr/subframe
// ---------------------------------------------------------------------------
module led_framebuffer #(
    parameter int BPC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [5:0]           wr_x,
    input  logic [5:0]           wr_y,
    input  logic [3*BPC-1:0]     wr_rgb,
    input  logic                 swap_req,
    output logic                 swap_pending,
    output logic                 swap_done,
    output logic                 display_bank,
    input  logic [12:0]          frame,
    input  logic [7:0]           subframe,
    input  logic [5:0]           x,
    input  logic [4:0]           addr,
    output logic [2:0]           rgb0,
    output logic [2:0]           rgb1
);

    typedef enum logic {IDLE, PENDING} swapState_t;

    // Each word address is {bank, row[4:0], col[5:0]}.
    logic [3*BPC-1:0] memTop [0:4095];
    logic [3*BPC-1:0] memBot [0:4095];

    swapState_t       state_q;
    logic             displayBank_q;
    logic             swapPending_q;
    logic             swapDone_q;
    logic [12:0]      frame_q;

    logic [3*BPC-1:0] readTop_q;
    logic [3*BPC-1:0] readBot_q;
    logic [BPC-1:0]   thr_q;
    logic [2:0]       rgb0_q;
    logic [2:0]       rgb1_q;
    logic [2:0]       rgb0_d;
    logic [2:0]       rgb1_d;

    logic [11:0]      wrAddr;
    logic [11:0]      rdAddr;
    logic             boundary;
    logic             unusedSubframe;

    // Only the low BPC subframe bits set the threshold.
    assign unusedSubframe = ^subframe[7:BPC];

    // Writes always land in the bank that is not on display, using the
    // bank register as it stands this cycle (the pre-swap back bank).
    assign wrAddr   = {~displayBank_q, wr_y[4:0], wr_x};
    assign rdAddr   = {displayBank_q, addr, x};
    assign boundary = (frame != frame_q);

    // A channel is lit when its value is strictly above the threshold, so
    // value 0 never lights and full scale lights in all but one subframe.
    function automatic logic [2:0] pwm(input logic [3*BPC-1:0] v,
                                       input logic [BPC-1:0]   t);
        return {v[3*BPC-1:2*BPC] > t, v[2*BPC-1:BPC] > t, v[BPC-1:0] > t};
    endfunction

    // Block RAM port behaviour: synchronous write into the back bank and a
    // registered read of the front bank. The threshold rides along with the
    // read data so both reach the compare stage together. None of this is
    // reset, matching real RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_y[5]) begin
            memTop[wrAddr] <= wr_rgb;
        end
        if (wr_en && wr_y[5]) begin
            memBot[wrAddr] <= wr_rgb;
        end
        readTop_q <= memTop[rdAddr];
        readBot_q <= memBot[rdAddr];
        thr_q     <= subframe[BPC-1:0];
    end

    // The PWM compare of the read data feeds the output registers.
    always_comb begin
        rgb0_d = pwm(readTop_q, thr_q);
        rgb1_d = pwm(readBot_q, thr_q);
    end

    // Second pipeline stage: the registered panel colour bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb0_q <= '0;
            rgb1_q <= '0;
        end else begin
            rgb0_q <= rgb0_d;
            rgb1_q <= rgb1_d;
        end
    end

    // Swap controller. A request made while idle waits for the next frame
    // change; if the frame changes in the same cycle as the request, the
    // swap happens right away. Further requests while pending are absorbed
    // so only one swap results. A reset drops any pending swap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            displayBank_q <= 1'b0;
            swapPending_q <= 1'b0;
            swapDone_q    <= 1'b0;
            frame_q       <= '0;
        end else begin
            frame_q    <= frame;
            swapDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (swap_req) begin
                        if (boundary) begin
                            displayBank_q <= ~displayBank_q;
                            swapDone_q    <= 1'b1;
                        end else begin
                            state_q       <= PENDING;
                            swapPending_q <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (boundary) begin
                        displayBank_q <= ~displayBank_q;
                        swapDone_q    <= 1'b1;
                        swapPending_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    swapPending_q <= 1'b0;
                end
            endcase
        end
    end

    assign swap_pending = swapPending_q;
    assign swap_done    = swapDone_q;
    assign display_bank = displayBank_q;
    assign rgb0         = rgb0_q;
    assign rgb1         = rgb1_q;

endmodule

// File: tb/tb_led_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_led_framebuffer
//
// Directed bench for led_framebuffer: reset values, write-then-swap, PWM
// thresholds on the top and bottom halves, swap gating, a swap coinciding
// with a request and a write, reset during a pending swap, frame counter
// wrap-around and a back-to-back column sweep.
// ---------------------------------------------------------------------------
module tb_led_framebuffer;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [5:0]  wr_x;
    logic [5:0]  wr_y;
    logic [11:0] wr_rgb;
    logic        swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic        display_bank;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x;
    logic [4:0]  addr;
    logic [2:0]  rgb0;
    logic [2:0]  rgb1;

    int checkCount;
    int errorCount;

    led_framebuffer #(.BPC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_rgb       (wr_rgb),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .display_bank (display_bank),
        .frame        (frame),
        .subframe     (subframe),
        .x            (x),
        .addr         (addr),
        .rgb0         (rgb0),
        .rgb1         (rgb1)
    );

    // 100 MHz pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advances one clock; inputs are then driven and outputs sampled 1ns
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes one pixel into the current back bank.
    task automatic writePixel(input logic [5:0] xv, input logic [5:0] yv,
                              input logic [11:0] v);
        wr_en  = 1'b1;
        wr_x   = xv;
        wr_y   = yv;
        wr_rgb = v;
        tick();
        wr_en  = 1'b0;
    endtask

    // Presents one scan position and waits out the 2-cycle read latency.
    task automatic applyStimulus(input logic [5:0] xv, input logic [4:0] av,
                                 input logic [7:0] sv);
        x        = xv;
        addr     = av;
        subframe = sv;
        tick();
        tick();
    endtask

    // Expected panel bits for a pixel value at a given threshold.
    function automatic logic [2:0] pwmBits(input logic [11:0] v, input int thr);
        logic [3:0] t;
        t = thr[3:0];
        return {v[11:8] > t, v[7:4] > t, v[3:0] > t};
    endfunction

    // Known gradient used for the column sweep.
    function automatic logic [11:0] gradPix(input int xv);
        logic [5:0] xs;
        xs = xv[5:0];
        return {xs[3:0], xs[5:2], 4'd15 - xs[3:0]};
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_x     = '0;
        wr_y     = '0;
        wr_rgb   = '0;
        swap_req = 1'b0;
        frame    = '0;
        subframe = '0;
        x        = '0;
        addr     = '0;

        $display("[TB] reset values");
        tick();
        tick();
        checkOutput("rst_rgb0", 16'(rgb0), 16'h0);
        checkOutput("rst_rgb1", 16'(rgb1), 16'h0);
        checkOutput("rst_bank", 16'(display_bank), 16'h0);
        checkOutput("rst_pending", 16'(swap_pending), 16'h0);
        checkOutput("rst_done", 16'(swap_done), 16'h0);
        reset = 1'b0;
        tick();

        $display("[TB] fill back bank 1 and swap");
        writePixel(6'd3, 6'd5, 12'hF08);
        writePixel(6'd63, 6'd37, 12'h100);
        writePixel(6'd63, 6'd5, 12'h000);
        for (int i = 0; i < 64; i++) begin
            writePixel(6'(i), 6'd10, gradPix(i));
        end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        checkOutput("req_pending", 16'(swap_pending), 16'h1);
        checkOutput("req_bank", 16'(display_bank), 16'h0);
        frame = 13'd1;
        tick();
        checkOutput("swap1_done", 16'(swap_done), 16'h1);
        checkOutput("swap1_bank", 16'(display_bank), 16'h1);
        checkOutput("swap1_pending", 16'(swap_pending), 16'h0);
        tick();
        checkOutput("swap1_done_pulse", 16'(swap_done), 16'h0);

        $display("[TB] PWM sweep at x=3 addr=5");
        for (int t = 0; t < 16; t++) begin
            applyStimulus(6'd3, 5'd5, 8'(t));
            checkOutput($sformatf("pwm_top_t%0d", t), 16'(rgb0), 16'(pwmBits(12'hF08, t)));
        end

        $display("[TB] bottom half at x=63 addr=5");
        for (int t = 0; t < 16; t++) begin
            applyStimulus(6'd63, 5'd5, 8'(t + 16));
            checkOutput($sformatf("bot_rgb1_t%0d", t), 16'(rgb1), 16'((t == 0) ? 3'b100 : 3'b000));
            checkOutput($sformatf("bot_rgb0_t%0d", t), 16'(rgb0), 16'h0);
        end

        $display("[TB] back-to-back column sweep");
        addr     = 5'd10;
        subframe = 8'd5;
        for (int i = 0; i <= 64; i++) begin
            if (i < 64) x = 6'(i);
            tick();
            if (i >= 1) begin
                checkOutput($sformatf("sweep_x%0d", i - 1), 16'(rgb0), 16'(pwmBits(gradPix(i - 1), 5)));
            end
        end

        $display("[TB] swap gating");
        writePixel(6'd3, 6'd5, 12'h0F0);
        for (int k = 0; k < 3; k++) begin
            swap_req = 1'b1;
            tick();
            swap_req = 1'b0;
            tick();
            checkOutput($sformatf("gate_pending%0d", k), 16'(swap_pending), 16'h1);
            checkOutput($sformatf("gate_nodone%0d", k), 16'(swap_done), 16'h0);
        end
        applyStimulus(6'd3, 5'd5, 8'd0);
        checkOutput("gate_front_kept", 16'(rgb0), 16'(pwmBits(12'hF08, 0)));
        checkOutput("gate_bank_kept", 16'(display_bank), 16'h1);
        frame = 13'd2;
        tick();
        checkOutput("gate_done", 16'(swap_done), 16'h1);
        checkOutput("gate_bank", 16'(display_bank), 16'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("gate_single_done%0d", k), 16'(swap_done), 16'h0);
            checkOutput($sformatf("gate_single_bank%0d", k), 16'(display_bank), 16'h0);
        end
        checkOutput("gate_idle", 16'(swap_pending), 16'h0);
        applyStimulus(6'd3, 5'd5, 8'd0);
        checkOutput("gate_new_front", 16'(rgb0), 16'(pwmBits(12'h0F0, 0)));

        $display("[TB] request, boundary and write together");
        swap_req = 1'b1;
        frame    = 13'd3;
        wr_en    = 1'b1;
        wr_x     = 6'd3;
        wr_y     = 6'd5;
        wr_rgb   = 12'h00F;
        tick();
        swap_req = 1'b0;
        wr_en    = 1'b0;
        checkOutput("simul_done", 16'(swap_done), 16'h1);
        checkOutput("simul_bank", 16'(display_bank), 16'h1);
        checkOutput("simul_pending", 16'(swap_pending), 16'h0);
        applyStimulus(6'd3, 5'd5, 8'd0);
        checkOutput("simul_read_t0", 16'(rgb0), 16'h1);
        applyStimulus(6'd3, 5'd5, 8'd15);
        checkOutput("simul_read_t15", 16'(rgb0), 16'h0);

        $display("[TB] reset during pending swap");
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        checkOutput("rst2_pending_before", 16'(swap_pending), 16'h1);
        reset = 1'b1;
        tick();
        checkOutput("rst2_rgb0", 16'(rgb0), 16'h0);
        checkOutput("rst2_rgb1", 16'(rgb1), 16'h0);
        checkOutput("rst2_bank", 16'(display_bank), 16'h0);
        checkOutput("rst2_pending", 16'(swap_pending), 16'h0);
        checkOutput("rst2_done", 16'(swap_done), 16'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            frame = 13'(5 + k);
            tick();
            checkOutput($sformatf("rst2_nodone%0d", k), 16'(swap_done), 16'h0);
            checkOutput($sformatf("rst2_nobank%0d", k), 16'(display_bank), 16'h0);
        end

        $display("[TB] frame wrap-around");
        frame = 13'd8191;
        tick();
        checkOutput("wrap_noreq", 16'(swap_done), 16'h0);
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        checkOutput("wrap_pending", 16'(swap_pending), 16'h1);
        tick();
        checkOutput("wrap_hold", 16'(swap_done), 16'h0);
        frame = 13'd0;
        tick();
        checkOutput("wrap_done", 16'(swap_done), 16'h1);
        checkOutput("wrap_bank", 16'(display_bank), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
